// File: rtl/reorder_buffer.sv
// In-order commit reorder buffer: a circular queue of DEPTH entries with CDB
// completion, operand lookup, flush and a registered register-write commit port.
module reorder_buffer #(
    parameter int DEPTH = 8,
    parameter int TAG_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             alloc_valid,
    input  logic [4:0]       alloc_rd,
    output logic             alloc_ready,
    output logic [TAG_W-1:0] alloc_tag,
    input  logic             cdb_valid,
    input  logic [TAG_W-1:0] cdb_tag,
    input  logic [31:0]      cdb_data,
    input  logic [TAG_W-1:0] lookup_tag,
    output logic             lookup_done,
    output logic [31:0]      lookup_data,
    input  logic             flush,
    output logic             Reg_writevalid,
    output logic [4:0]       Reg_writeaddr,
    output logic [31:0]      Reg_writedata,
    output logic [TAG_W:0]   count
);

    localparam logic [TAG_W:0] FULL_COUNT = (TAG_W+1)'(DEPTH);

    logic [DEPTH-1:0] busy_q, busy_d;
    logic [DEPTH-1:0] done_q, done_d;
    logic [4:0]       rd_q   [DEPTH];
    logic [4:0]       rd_d   [DEPTH];
    logic [31:0]      data_q [DEPTH];
    logic [31:0]      data_d [DEPTH];
    logic [TAG_W-1:0] head_q, head_d;
    logic [TAG_W-1:0] tail_q, tail_d;
    logic [TAG_W:0]   count_q, count_d;
    logic             wr_valid_q, wr_valid_d;
    logic [4:0]       wr_addr_q, wr_addr_d;
    logic [31:0]      wr_data_q, wr_data_d;
    logic             alloc_fire_s;
    logic             commit_fire_s;

    // Only registered occupancy gates allocation, so a same-cycle commit never frees a slot.
    assign alloc_ready   = (count_q != FULL_COUNT);
    assign alloc_tag     = tail_q;
    assign alloc_fire_s  = alloc_valid && alloc_ready && !flush;
    assign commit_fire_s = busy_q[head_q] && done_q[head_q] && !flush;

    assign lookup_done    = busy_q[lookup_tag] && done_q[lookup_tag];
    assign lookup_data    = data_q[lookup_tag];
    assign Reg_writevalid = wr_valid_q;
    assign Reg_writeaddr  = wr_addr_q;
    assign Reg_writedata  = wr_data_q;
    assign count          = count_q;

    // Next-state: CDB completion, then commit, then allocation (allocation wins on a shared index).
    always_comb begin
        busy_d     = busy_q;
        done_d     = done_q;
        rd_d       = rd_q;
        data_d     = data_q;
        head_d     = head_q;
        tail_d     = tail_q;
        count_d    = count_q;
        wr_valid_d = 1'b0;
        wr_addr_d  = wr_addr_q;
        wr_data_d  = wr_data_q;
        if (flush) begin
            busy_d  = '0;
            done_d  = '0;
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            if (cdb_valid && busy_q[cdb_tag]) begin
                done_d[cdb_tag] = 1'b1;
                data_d[cdb_tag] = cdb_data;
            end else begin
                done_d = done_d;
            end
            if (commit_fire_s) begin
                busy_d[head_q] = 1'b0;
                done_d[head_q] = 1'b0;
                head_d         = head_q + TAG_W'(1);
                if (rd_q[head_q] != 5'd0) begin
                    wr_valid_d = 1'b1;
                    wr_addr_d  = rd_q[head_q];
                    wr_data_d  = data_q[head_q];
                end else begin
                    wr_valid_d = 1'b0;
                end
            end else begin
                head_d = head_q;
            end
            if (alloc_fire_s) begin
                busy_d[tail_q] = 1'b1;
                done_d[tail_q] = 1'b0;
                rd_d[tail_q]   = alloc_rd;
                tail_d         = tail_q + TAG_W'(1);
            end else begin
                tail_d = tail_q;
            end
            case ({alloc_fire_s, commit_fire_s})
                2'b10:   count_d = count_q + (TAG_W+1)'(1);
                2'b01:   count_d = count_q - (TAG_W+1)'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // Control state and commit port, cleared by reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            busy_q     <= '0;
            done_q     <= '0;
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
            wr_valid_q <= 1'b0;
            wr_addr_q  <= 5'd0;
            wr_data_q  <= 32'd0;
        end else begin
            busy_q     <= busy_d;
            done_q     <= done_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
            count_q    <= count_d;
            wr_valid_q <= wr_valid_d;
            wr_addr_q  <= wr_addr_d;
            wr_data_q  <= wr_data_d;
        end
    end

    // Entry payload; only meaningful while busy, so it needs no reset.
    always_ff @(posedge clk) begin
        rd_q   <= rd_d;
        data_q <= data_d;
    end

endmodule

// File: tb/tb_reorder_buffer.sv
// Directed bench for reorder_buffer; commit writes are checked by a scoreboard monitor.
module tb_reorder_buffer;

    localparam int DEPTH = 8;
    localparam int TAG_W = 3;

    logic             clk = 1'b0;
    logic             reset;
    logic             alloc_valid;
    logic [4:0]       alloc_rd;
    logic             alloc_ready;
    logic [TAG_W-1:0] alloc_tag;
    logic             cdb_valid;
    logic [TAG_W-1:0] cdb_tag;
    logic [31:0]      cdb_data;
    logic [TAG_W-1:0] lookup_tag;
    logic             lookup_done;
    logic [31:0]      lookup_data;
    logic             flush;
    logic             Reg_writevalid;
    logic [4:0]       Reg_writeaddr;
    logic [31:0]      Reg_writedata;
    logic [TAG_W:0]   count;

    typedef struct {
        logic [4:0]  a;
        logic [31:0] d;
    } wr_t;

    wr_t exp_q[$];
    int  total = 0;
    int  bad   = 0;

    reorder_buffer #(.DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
        .clk(clk), .reset(reset),
        .alloc_valid(alloc_valid), .alloc_rd(alloc_rd),
        .alloc_ready(alloc_ready), .alloc_tag(alloc_tag),
        .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
        .lookup_tag(lookup_tag), .lookup_done(lookup_done), .lookup_data(lookup_data),
        .flush(flush),
        .Reg_writevalid(Reg_writevalid), .Reg_writeaddr(Reg_writeaddr),
        .Reg_writedata(Reg_writedata), .count(count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Scoreboard monitor: every write strobe must match the next expected commit.
    always @(negedge clk) begin
        if (Reg_writevalid !== 1'b0) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_write: got addr %0h data %0h expected no write",
                         Reg_writeaddr, Reg_writedata);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                chk("wr_addr", {27'd0, Reg_writeaddr}, {27'd0, e.a});
                chk("wr_data", Reg_writedata, e.d);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [4:0] a, input logic [31:0] d);
        wr_t e;
        e.a = a;
        e.d = d;
        exp_q.push_back(e);
    endtask

    task automatic alloc(input logic [4:0] rd);
        alloc_valid = 1'b1;
        alloc_rd    = rd;
        tick();
        alloc_valid = 1'b0;
    endtask

    task automatic cdb(input logic [TAG_W-1:0] tag, input logic [31:0] d);
        cdb_valid = 1'b1;
        cdb_tag   = tag;
        cdb_data  = d;
        tick();
        cdb_valid = 1'b0;
    endtask

    task automatic reset_pulse();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    task automatic look(input logic [TAG_W-1:0] tag, input logic exp_done);
        lookup_tag = tag;
        #1;
        chk("lookup_done", {31'd0, lookup_done}, {31'd0, exp_done});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; alloc_valid = 1'b0; alloc_rd = 5'd0; cdb_valid = 1'b0;
        cdb_tag = '0; cdb_data = 32'd0; lookup_tag = '0; flush = 1'b0;
        tick();
        tick();
        reset = 1'b0;

        // Reset state
        chk("rst_count", {28'd0, count}, 32'd0);
        chk("rst_ready", {31'd0, alloc_ready}, 32'd1);
        chk("rst_tag", {29'd0, alloc_tag}, 32'd0);
        chk("rst_wv", {31'd0, Reg_writevalid}, 32'd0);
        chk("rst_waddr", {27'd0, Reg_writeaddr}, 32'd0);
        chk("rst_wdata", Reg_writedata, 32'd0);

        // Single instruction, minimum CDB-to-write latency
        alloc(5'd5);
        push(5'd5, 32'hDEADBEEF);
        cdb(3'd0, 32'hDEADBEEF);
        chk("lat_n1_wv", {31'd0, Reg_writevalid}, 32'd0);
        tick();
        chk("lat_n2_wv", {31'd0, Reg_writevalid}, 32'd1);
        tick();
        chk("lat_n3_wv", {31'd0, Reg_writevalid}, 32'd0);
        chk("lat_count", {28'd0, count}, 32'd0);

        // Out-of-order completion commits in order
        reset_pulse();
        alloc(5'd3);
        alloc(5'd4);
        cdb(3'd1, 32'h44);
        tick();
        chk("ooo_wv", {31'd0, Reg_writevalid}, 32'd0);
        chk("ooo_count", {28'd0, count}, 32'd2);
        look(3'd1, 1'b1);
        chk("ooo_ldata", lookup_data, 32'h44);
        look(3'd0, 1'b0);
        push(5'd3, 32'h33);
        push(5'd4, 32'h44);
        cdb(3'd0, 32'h33);
        tick();
        chk("ooo_w1", {31'd0, Reg_writevalid}, 32'd1);
        tick();
        chk("ooo_w2", {31'd0, Reg_writevalid}, 32'd1);
        tick();
        chk("ooo_w3", {31'd0, Reg_writevalid}, 32'd0);
        chk("ooo_count0", {28'd0, count}, 32'd0);

        // Fill, reject when full, wrap-around, no full-bypass
        reset_pulse();
        for (int i = 0; i < DEPTH; i++) begin
            chk("fill_tag", {29'd0, alloc_tag}, i);
            alloc(5'(i + 1));
        end
        chk("full_ready", {31'd0, alloc_ready}, 32'd0);
        chk("full_count", {28'd0, count}, 32'd8);
        alloc(5'd9);
        chk("full_ign_count", {28'd0, count}, 32'd8);
        chk("full_ign_tag", {29'd0, alloc_tag}, 32'd0);
        push(5'd1, 32'h100);
        cdb(3'd0, 32'h100);
        tick();
        chk("wrap_count", {28'd0, count}, 32'd7);
        chk("wrap_ready", {31'd0, alloc_ready}, 32'd1);
        chk("wrap_tag", {29'd0, alloc_tag}, 32'd0);
        alloc(5'd20);
        chk("wrap_alloc_count", {28'd0, count}, 32'd8);
        chk("wrap_alloc_tag", {29'd0, alloc_tag}, 32'd1);
        push(5'd2, 32'h200);
        cdb(3'd1, 32'h200);
        alloc_valid = 1'b1;
        alloc_rd    = 5'd21;
        #1;
        chk("nobypass_ready", {31'd0, alloc_ready}, 32'd0);
        tick();
        alloc_valid = 1'b0;
        chk("nobypass_count", {28'd0, count}, 32'd7);
        chk("nobypass_tag", {29'd0, alloc_tag}, 32'd1);
        reset_pulse();
        chk("midrst_count", {28'd0, count}, 32'd0);
        tick();
        chk("midrst_wv", {31'd0, Reg_writevalid}, 32'd0);

        // rd==0 retires silently
        alloc(5'd0);
        cdb(3'd0, 32'h55);
        chk("rd0_wv1", {31'd0, Reg_writevalid}, 32'd0);
        tick();
        chk("rd0_count", {28'd0, count}, 32'd0);
        tick();
        chk("rd0_wv2", {31'd0, Reg_writevalid}, 32'd0);

        // Flush, then the same scenario with reset
        for (int m = 0; m < 2; m++) begin
            reset_pulse();
            alloc(5'd6);
            alloc(5'd7);
            alloc(5'd8);
            cdb(3'd1, 32'h71);
            cdb(3'd0, 32'h60);
            if (m == 0) flush = 1'b1;
            else        reset = 1'b1;
            tick();
            flush = 1'b0;
            reset = 1'b0;
            chk("fl_count", {28'd0, count}, 32'd0);
            chk("fl_wv", {31'd0, Reg_writevalid}, 32'd0);
            chk("fl_tag", {29'd0, alloc_tag}, 32'd0);
            chk("fl_ready", {31'd0, alloc_ready}, 32'd1);
            look(3'd1, 1'b0);
            tick();
            chk("fl_wv2", {31'd0, Reg_writevalid}, 32'd0);
        end

        // Simultaneous alloc+commit, CDB to idle entry, alloc/CDB index collision
        reset_pulse();
        for (int i = 0; i < 4; i++) alloc(5'(10 + i));
        push(5'd10, 32'hA0);
        cdb(3'd0, 32'hA0);
        chk("both_pre_count", {28'd0, count}, 32'd4);
        alloc(5'd14);
        chk("both_count", {28'd0, count}, 32'd4);
        chk("both_tag", {29'd0, alloc_tag}, 32'd5);
        cdb(3'd6, 32'h66);
        chk("idle_cdb_count", {28'd0, count}, 32'd4);
        look(3'd6, 1'b0);
        alloc_valid = 1'b1;
        alloc_rd    = 5'd15;
        cdb_valid   = 1'b1;
        cdb_tag     = 3'd5;
        cdb_data    = 32'h77;
        tick();
        alloc_valid = 1'b0;
        cdb_valid   = 1'b0;
        chk("coll_count", {28'd0, count}, 32'd5);
        look(3'd5, 1'b0);
        tick();
        tick();
        tick();
        chk("sb_drained", exp_q.size(), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
